strobe_gen: RTL
===============

Name: strobe_gen

Overview:
- Write-side counterpart of the edge-captured register model.
- Accepts synchronous write requests in the `clock` domain and replays them as a slow, edge-encoded write clock `c` with held data `d`.
- Any downstream register that detects the rising edge of `c` captures `d` exactly once per request.
- Sits between the bus/CPU write logic and the emulated asynchronously-clocked chip registers.

Parameters:
- DW, 8: width of the data word.
- SETUP, 1: cycles `d` is stable with `c`=0 before `c` rises (0..15).
- HIGH, 2: cycles `c` is held 1 (1..15).
- LOW, 2: cycles `c` is held 0 after falling, before the next request may start (1..15).
- DEPTH, 4: pending-request FIFO depth (power of 2, >=2).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- resb  in  1  asynchronous reset, active low.
- wr_valid  in  1  write request present.
- wr_ready  out  1  FIFO can accept; a transfer occurs when wr_valid & wr_ready at a clock edge.
- wr_data  in  DW  data for the request.
- c  out  1  generated write clock, registered.
- d  out  DW  generated data, registered.
- busy  out  1  state != IDLE or FIFO non-empty.
- level  out  log2(DEPTH)+1  number of queued (not yet started) requests.

Behaviour:
- Reset (resb=0, asynchronous):
  - c=0, d=0, FIFO emptied, level=0, busy=0, wr_ready=0, state=IDLE.
  - A write in progress is aborted with c forced low immediately, so no spurious rising edge is produced.
  - wr_ready becomes 1 on the first edge after resb deasserts.
- FIFO:
  - wr_ready = (level != DEPTH), driven from registered state only.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when non-full: level unchanged.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE, SETUP, HIGH, LOW):
  - IDLE:
    - If FIFO non-empty: pop the head and load it into d.
    - Go to SETUP with counter = SETUP-1, or directly to HIGH with c=1 if SETUP=0.
  - SETUP: c=0, d held. When the counter reaches 0: c<=1, go to HIGH with counter = HIGH-1.
  - HIGH: c=1, d held. When the counter reaches 0: c<=0, go to LOW with counter = LOW-1.
  - LOW: c=0, d held. When the counter reaches 0: go to IDLE.
  - A back-to-back request is popped in that same IDLE cycle, giving one extra c=0 cycle between writes.
- Timing and data hold:
  - d changes only on IDLE->SETUP/HIGH transitions.
  - d retains the last written value indefinitely in IDLE.
  - Per request, c rises exactly once and falls exactly once.
  - Each request occupies 1+SETUP+HIGH+LOW cycles, counted from the pop.
- Latency: request accepted at edge E0 with the block idle and the FIFO empty:
  - pop at E1 (d valid after E1);
  - c rises after edge E1+SETUP;
  - c falls after E1+SETUP+HIGH.
- Ordering: strictly FIFO. Equal consecutive data values still produce separate c pulses.
- Counter widths: 4 bits. Parameter values outside the stated ranges are illegal and are not checked.

Optional Feature:
- Macro: STROBE_GEN_BYPASS_EN.
- When defined:
  - A request accepted while state=IDLE and level=0 skips the FIFO.
  - d is loaded at the accept edge E0 and the state machine enters SETUP (or HIGH if SETUP=0) at that same edge.
  - c rises after E0+SETUP, one cycle earlier than the non-bypass latency.
  - level stays 0 for that request.
  - All other cases are unchanged.
- When undefined: every request goes through the FIFO with the latency given above.

Test Plan:
- Reset, then single write 8'hA5 (defaults):
  - d=A5 after E1;
  - c=1 for exactly 2 cycles, starting after E2;
  - then c=0;
  - busy drops after E6.
  - With STROBE_GEN_BYPASS_EN, c rises one cycle earlier.
- Burst of 6 writes 01..06 on consecutive cycles (DEPTH=4):
  - wr_ready drops while level=4;
  - all 6 values appear on d in order, each with exactly one c rising edge;
  - cycle count between successive rising edges = 6.
- Two identical writes 8'h3C: two distinct c pulses with d=3C throughout and c low for at least 3 cycles between them.
- SETUP=0, HIGH=1, LOW=1: c rises in the same cycle d is loaded; 1-cycle high; period 3 cycles per request.
- Assert resb=0 during the HIGH phase:
  - c goes to 0 without waiting for a clock edge;
  - d=0, level=0;
  - after release, no pulse occurs until a new write is accepted.
- Simultaneous push and pop at level=2: level stays 2; with level=DEPTH and wr_valid=1, no data is accepted and the FIFO contents are unchanged.

Source files
------------

// File: rtl/strobe_gen.sv
// ============================================================================
//  Module      : strobe_gen
//  Description : Replays synchronous write requests as a slow, edge-encoded
//                write clock `c` with held data `d`. Requests are queued in a
//                small FIFO and played out one at a time as
//                SETUP (c=0) -> HIGH (c=1) -> LOW (c=0) -> IDLE, so a
//                downstream register clocked by the rising edge of `c`
//                captures `d` exactly once per request.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock    in   system clock, all state updates on its rising edge
//    resb     in   asynchronous reset, active low
//    wr_valid in   write request present
//    wr_ready out  FIFO can accept (transfer when wr_valid & wr_ready)
//    wr_data  in   [DW-1:0] data for the request
//    c        out  generated write clock (registered)
//    d        out  [DW-1:0] generated data (registered)
//    busy     out  sequencer active or requests still queued
//    level    out  [$clog2(DEPTH):0] number of queued, not yet started requests
// ----------------------------------------------------------------------------
//  Build option
//    STROBE_GEN_BYPASS_EN : a request accepted while idle with an empty FIFO
//                           is started at the accept edge, skipping the FIFO.
// ============================================================================
`default_nettype none

module strobe_gen #(
   parameter int DW    = 8,
   parameter int SETUP = 1,
   parameter int HIGH  = 2,
   parameter int LOW   = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     resb,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DW-1:0]            wr_data,
   output logic                     c,
   output logic [DW-1:0]            d,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   // Counter reload values; each phase lasts (reload + 1) cycles.
   localparam logic [3:0]  C_SETUP_LD = (SETUP == 0) ? 4'd0 : 4'(SETUP - 1);
   localparam logic [3:0]  C_HIGH_LD  = 4'(HIGH - 1);
   localparam logic [3:0]  C_LOW_LD   = 4'(LOW - 1);
   localparam logic [AW:0] C_FULL     = (AW + 1)'(DEPTH);
   localparam logic [AW:0] C_ONE      = (AW + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   state_t          state_q;
   logic [3:0]      cnt_q;
   logic            c_q;
   logic [DW-1:0]   d_q;
   logic            init_q;

   logic [DW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q,  level_d;

   logic            push_req;
   logic            bypass;
   logic            fifo_push;
   logic            pop;
   logic [DW-1:0]   load_data;

   // init_q keeps wr_ready low until the first edge after reset release.
   assign wr_ready  = init_q & (level_q != C_FULL);
   assign push_req  = wr_valid & wr_ready;

`ifdef STROBE_GEN_BYPASS_EN
   assign bypass    = push_req & (state_q == ST_IDLE) & (level_q == '0);
`else
   assign bypass    = 1'b0;
`endif

   assign fifo_push = push_req & ~bypass;
   assign pop       = (state_q == ST_IDLE) & (level_q != '0);
   assign load_data = pop ? mem_q[rd_ptr_q] : wr_data;

   assign c     = c_q;
   assign d     = d_q;
   assign level = level_q;
   assign busy  = (state_q != ST_IDLE) | (level_q != '0);

   // ------------------------------------------------------------------------
   // FIFO bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (fifo_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({fifo_push, pop})
         2'b10:   level_d = level_q + C_ONE;
         2'b01:   level_d = level_q - C_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock or negedge resb) begin
      if (!resb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         init_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         init_q   <= 1'b1;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers.
   always_ff @(posedge clock) begin
      if (fifo_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Strobe sequencer. Reset forces c low asynchronously so an aborted
   // write never produces a spurious rising edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resb) begin
      if (!resb) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         d_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop || bypass) begin
                  d_q <= load_data;
                  if (SETUP == 0) begin
                     c_q     <= 1'b1;
                     state_q <= ST_HIGH;
                     cnt_q   <= C_HIGH_LD;
                  end else begin
                     state_q <= ST_SETUP;
                     cnt_q   <= C_SETUP_LD;
                  end
               end
            end
            ST_SETUP: begin
               if (cnt_q == 4'd0) begin
                  c_q     <= 1'b1;
                  state_q <= ST_HIGH;
                  cnt_q   <= C_HIGH_LD;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_HIGH: begin
               if (cnt_q == 4'd0) begin
                  c_q     <= 1'b0;
                  state_q <= ST_LOW;
                  cnt_q   <= C_LOW_LD;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_LOW: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               c_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
